// File: rtl/fb_rect_writer.sv
// Rectangle-fill writer for the 8-bit colour frame buffer: clips each command to the
// screen and emits one pixel write per clock, stalling while the scan-out reader is active.
module fb_rect_writer #(
  parameter int FB_WIDTH  = 480,
  parameter int FB_HEIGHT = 360
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  input  logic        active,
  output logic [17:0] fb_addr,
  output logic        fb_we,
  output logic [7:0]  fb_data_in,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  localparam logic [9:0]  FBW   = 10'(FB_WIDTH);
  localparam logic [9:0]  FBH   = 10'(FB_HEIGHT);
  localparam logic [17:0] FBW18 = 18'(FB_WIDTH);

  state_t      state;
  logic [9:0]  x_r, y_r, w_r, h_r;
  logic [7:0]  color_r;
  logic [9:0]  ew, eh, col, row;
  logic [17:0] row_base;

  logic [9:0]  room_x, room_y, ew_calc, eh_calc;
  logic [17:0] row_base_calc;

  // Clipped extent and first-row address; the room terms are only meaningful on-screen.
  always_comb begin
    room_x        = FBW - x_r;
    room_y        = FBH - y_r;
    ew_calc       = (x_r >= FBW) ? 10'd0 : ((w_r < room_x) ? w_r : room_x);
    eh_calc       = (y_r >= FBH) ? 10'd0 : ((h_r < room_y) ? h_r : room_y);
    row_base_calc = ({8'd0, y_r} * FBW18) + {8'd0, x_r};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data_in <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_r        <= '0;
      y_r        <= '0;
      w_r        <= '0;
      h_r        <= '0;
      color_r    <= '0;
      ew         <= '0;
      eh         <= '0;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
    end else begin
      fb_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            x_r       <= cmd_x;
            y_r       <= cmd_y;
            w_r       <= cmd_w;
            h_r       <= cmd_h;
            color_r   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          ew       <= ew_calc;
          eh       <= eh_calc;
          row_base <= row_base_calc;
          col      <= '0;
          row      <= '0;
          state    <= (ew_calc == 10'd0 || eh_calc == 10'd0) ? DONE : WRITE;
        end
        WRITE: begin
          // A stalled cycle leaves address, counters and state untouched.
          if (!active) begin
            fb_we      <= 1'b1;
            fb_addr    <= row_base + 18'(col);
            fb_data_in <= color_r;
            if (col == ew - 10'd1) begin
              col      <= '0;
              row      <= row + 10'd1;
              row_base <= row_base + FBW18;
              if (row == eh - 10'd1)
                state <= DONE;
            end else begin
              col <= col + 10'd1;
            end
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: a queue of expected (addr, colour) writes is built
// from the clipping rule and drained as the DUT writes; latency is checked per command.
module tb_fb_rect_writer;

  localparam int W = 480;
  localparam int H = 360;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        active = 1'b0;
  logic [17:0] fb_addr;
  logic        fb_we;
  logic [7:0]  fb_data_in;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [7:0]  color;
    logic [17:0] addr;
  } pixel_t;

  pixel_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, accept_cyc = 0, stalls = 0, writes = 0, done_cnt = 0, done_cyc = 0;

  fb_rect_writer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .active(active), .fb_addr(fb_addr), .fb_we(fb_we), .fb_data_in(fb_data_in),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: pixels written are matched against the expected queue in order, stalled
  // WRITE edges are counted, and done pulses are recorded.
  task automatic step();
    logic   a_edge;
    bit     pending;
    pixel_t e;
    a_edge  = active;
    pending = exp_q.size() > 0;
    if (a_edge && pending && (cyc + 1 >= accept_cyc + 2)) stalls++;
    @(posedge Clk);
    #1;
    cyc++;
    if (fb_we === 1'b1) begin
      writes++;
      checkOutput("we_while_active", 32'(a_edge), 0);
      if (exp_q.size() == 0) begin
        checkOutput("write_when_none_expected", 32'(fb_we), 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", 32'(fb_addr), 32'(e.addr));
        checkOutput("write_data", 32'(fb_data_in), 32'(e.color));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // Reference model: clip to the screen, then list pixels row-major.
  task automatic pushModel(input int x, input int y, input int w, input int h,
                           input logic [7:0] color, output int area);
    int ew, eh;
    pixel_t p;
    ew = (x >= W) ? 0 : ((w < W - x) ? w : W - x);
    eh = (y >= H) ? 0 : ((h < H - y) ? h : H - y);
    area = ew * eh;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++) begin
        p.addr  = 18'((y + r) * W + x + c);
        p.color = color;
        exp_q.push_back(p);
      end
  endtask

  // mode 0: active low; mode 1: one stall of stall_len after stall_after writes; mode 2: random active.
  task automatic waitDone(input int area, input int mode, input int stall_after,
                          input int stall_len, input string tag);
    int start_cnt, n, w0, budget;
    bit stalled;
    start_cnt = done_cnt;
    n = 0;
    w0 = writes;
    stalled = 0;
    budget = 4 * area + stall_len + 40;
    while (done_cnt == start_cnt && n < budget) begin
      if (mode == 1 && !stalled && (writes - w0) == stall_after) begin
        active = 1'b1;
        repeat (stall_len) step();
        active = 1'b0;
        stalled = 1;
        n += stall_len;
      end else begin
        if (mode == 2) active = 1'($urandom_range(0, 1));
        step();
        n++;
      end
    end
    active = 1'b0;
    checkOutput({tag, "_done_latency"}, (done_cnt == start_cnt) ? 0 : done_cyc - accept_cyc,
                area + 2 + stalls);
    checkOutput({tag, "_pixels_left"}, exp_q.size(), 0);
    step();
    checkOutput({tag, "_done_pulses"}, done_cnt - start_cnt, 1);
    checkOutput({tag, "_ready_after"}, 32'(cmd_ready), 1);
    checkOutput({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input logic [7:0] color, input int mode,
                               input int stall_after, input int stall_len, input string tag);
    int area;
    pushModel(x, y, w, h, color, area);
    cmd_x = 10'(x);
    cmd_y = 10'(y);
    cmd_w = 10'(w);
    cmd_h = 10'(h);
    cmd_color = color;
    cmd_valid = 1'b1;
    checkOutput({tag, "_ready_before"}, 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    accept_cyc = cyc;
    stalls = 0;
    checkOutput({tag, "_busy_on_accept"}, 32'(busy), 1);
    checkOutput({tag, "_ready_on_accept"}, 32'(cmd_ready), 0);
    waitDone(area, mode, stall_after, stall_len, tag);
  endtask

  initial begin
    int a0, a1, d0, rx, ry;
    $display("[TB] fb_rect_writer bench start");

    repeat (3) step();
    Reset = 1'b0;
    step();
    checkOutput("reset_ready", 32'(cmd_ready), 1);
    checkOutput("reset_we", 32'(fb_we), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_addr", 32'(fb_addr), 0);

    applyStimulus(2, 1, 3, 2, 8'hE0, 0, 0, 0, "basic");
    applyStimulus(2, 1, 3, 2, 8'hE0, 1, 2, 4, "stall");
    applyStimulus(478, 359, 10, 10, 8'h1C, 0, 0, 0, "clip");
    applyStimulus(10, 10, 0, 5, 8'h03, 0, 0, 0, "zero_w");
    applyStimulus(20, 400, 4, 4, 8'h44, 0, 0, 0, "off_y");

    // Off-screen command, with a second command held on cmd_valid while busy.
    pushModel(480, 20, 5, 5, 8'hAA, a0);
    cmd_x = 10'd480; cmd_y = 10'd20; cmd_w = 10'd5; cmd_h = 10'd5; cmd_color = 8'hAA;
    cmd_valid = 1'b1;
    step();
    accept_cyc = cyc;
    stalls = 0;
    cmd_x = 10'd7; cmd_y = 10'd3; cmd_w = 10'd2; cmd_h = 10'd1; cmd_color = 8'h5A;
    step();
    checkOutput("held_ready_low", 32'(cmd_ready), 0);
    checkOutput("held_busy_high", 32'(busy), 1);
    step();
    checkOutput("held_done_latency", (done === 1'b1) ? cyc - accept_cyc : 0, 2);
    checkOutput("held_ready_back", 32'(cmd_ready), 1);
    pushModel(7, 3, 2, 1, 8'h5A, a1);
    step();
    cmd_valid = 1'b0;
    accept_cyc = cyc;
    stalls = 0;
    checkOutput("held_second_accepted", 32'(busy), 1);
    waitDone(a1, 0, 0, 0, "held_second");

    // Reset in the middle of a large fill.
    pushModel(0, 0, 100, 100, 8'h33, a0);
    cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 10'd100; cmd_h = 10'd100; cmd_color = 8'h33;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    accept_cyc = cyc;
    repeat (20) step();
    d0 = done_cnt;
    Reset = 1'b1;
    step();
    exp_q.delete();
    checkOutput("midreset_we", 32'(fb_we), 0);
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_ready", 32'(cmd_ready), 1);
    checkOutput("midreset_done", 32'(done), 0);
    Reset = 1'b0;
    repeat (5) step();
    checkOutput("midreset_no_done", done_cnt - d0, 0);
    applyStimulus(100, 200, 4, 3, 8'hC3, 0, 0, 0, "after_reset");

    // Randomised commands, some straddling the right/bottom edges, with random stalls.
    for (int i = 0; i < 10; i++) begin
      rx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 479)) : int'($urandom_range(470, 490));
      ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 359)) : int'($urandom_range(352, 366));
      applyStimulus(rx, ry, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                    8'($urandom), 2, 0, 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
